// File: rtl/gmii_rx_framer_if.sv
// gmii_rx_framer_if: framed byte stream leaving the GMII receive framer.
//   ov_data[8]   first/last byte marker
//   ov_data[7:0] frame byte (all zero when o_data_wr is low)
//   o_data_wr    one-cycle strobe per byte, contiguous within a frame
interface gmii_rx_framer_if;
  logic [8:0] ov_data;
  logic       o_data_wr;

  modport master (output ov_data, output o_data_wr);
  modport slave  (input  ov_data, input  o_data_wr);
endinterface

// File: rtl/gmii_rx_framer.sv
// gmii_rx_framer: strips preamble/SFD from a GMII receive stream and emits a
// 9-bit byte stream whose bit 8 marks the first and last byte of every frame.
// Runt, errored, oversize and badly-preambled frames are counted and dropped
// or truncated, so downstream only ever sees well-delimited frames.
// Optional feature macro GMII_FCS_STRIP_EN: when defined, the trailing four
// FCS bytes are held back and never emitted (delay depth 5 instead of 1).
module gmii_rx_framer #(
  parameter int MAX_LEN = 1518
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  iv_gmii_rxd,
  input  logic        i_gmii_rx_dv,
  input  logic        i_gmii_rx_er,
  input  logic        i_cycle_start,
  gmii_rx_framer_if.master stream,
  output logic [18:0] ov_relative_time,
  output logic [15:0] ov_frame_cnt,
  output logic [15:0] ov_err_cnt
);

`ifdef GMII_FCS_STRIP_EN
  localparam int DEPTH = 5;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [2:0]  FULL     = 3'(DEPTH);
  localparam logic [11:0] LAST_IDX = 12'(MAX_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

  state_t      state, state_next;
  logic [7:0]  hold [DEPTH];
  logic [2:0]  fill;
  logic [11:0] out_cnt;
  logic [18:0] rel_cnt;
  logic [18:0] cur_time;
  logic        emit, emit_mark, shift_en, frame_start;
  logic        frame_inc, err_inc, time_latch;

  // A cycle-start pulse makes the current cycle read as time zero.
  assign cur_time = i_cycle_start ? 19'd0 : rel_cnt;

  // Free-running relative-time counter, wrapping naturally at 19 bits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rel_cnt <= '0;
    else          rel_cnt <= cur_time + 19'd1;
  end

  // Framer state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_next;
  end

  // Next-state and per-cycle action decode; emitted byte is always the oldest held one.
  always_comb begin
    state_next  = state;
    emit        = 1'b0;
    emit_mark   = 1'b0;
    shift_en    = 1'b0;
    frame_start = 1'b0;
    frame_inc   = 1'b0;
    err_inc     = 1'b0;
    time_latch  = 1'b0;
    case (state)
      S_IDLE, S_PREAMBLE: begin
        if (!i_gmii_rx_dv) begin
          state_next = S_IDLE;
        end else if (iv_gmii_rxd == 8'h55) begin
          state_next = S_PREAMBLE;
        end else if (iv_gmii_rxd == 8'hD5) begin
          state_next  = S_DATA;
          frame_start = 1'b1;
          time_latch  = 1'b1;
        end else begin
          state_next = S_DROP;
          err_inc    = 1'b1;
        end
      end
      S_DATA: begin
        if (!i_gmii_rx_dv) begin
          // More than DEPTH bytes received means at least one byte already went out.
          if (out_cnt != 12'd0) begin
            emit      = 1'b1;
            emit_mark = 1'b1;
            frame_inc = 1'b1;
          end else begin
            err_inc = 1'b1;
          end
          state_next = S_IDLE;
        end else if (i_gmii_rx_er) begin
          if (out_cnt != 12'd0) begin
            emit      = 1'b1;
            emit_mark = 1'b1;
          end
          err_inc    = 1'b1;
          state_next = S_DROP;
        end else begin
          shift_en = 1'b1;
          if (fill == FULL) begin
            emit      = 1'b1;
            emit_mark = (out_cnt == 12'd0) || (out_cnt == LAST_IDX);
            if (out_cnt == LAST_IDX) begin
              err_inc    = 1'b1;
              state_next = S_DROP;
            end
          end
        end
      end
      S_DROP: begin
        if (!i_gmii_rx_dv) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Delay line, fill level and emitted-byte count for the frame in progress.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) hold[i] <= '0;
      fill    <= '0;
      out_cnt <= '0;
    end else begin
      if (shift_en) begin
        for (int i = DEPTH - 1; i > 0; i--) hold[i] <= hold[i-1];
        hold[0] <= iv_gmii_rxd;
      end
      if (frame_start) begin
        fill    <= '0;
        out_cnt <= '0;
      end else begin
        if (shift_en && fill != FULL) fill <= fill + 3'd1;
        if (emit) out_cnt <= out_cnt + 12'd1;
      end
    end
  end

  // Registered outputs: byte stream, captured timestamp and event counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stream.ov_data   <= '0;
      stream.o_data_wr <= 1'b0;
      ov_relative_time <= '0;
      ov_frame_cnt     <= '0;
      ov_err_cnt       <= '0;
    end else begin
      stream.ov_data   <= emit ? {emit_mark, hold[DEPTH-1]} : 9'd0;
      stream.o_data_wr <= emit;
      if (time_latch) ov_relative_time <= cur_time;
      if (frame_inc)  ov_frame_cnt     <= ov_frame_cnt + 16'd1;
      if (err_inc)    ov_err_cnt       <= ov_err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// tb_gmii_rx_framer: directed self-checking bench for gmii_rx_framer with
// MAX_LEN=100. Expected values adapt to GMII_FCS_STRIP_EN (4 FCS bytes held back).
module tb_gmii_rx_framer;

`ifdef GMII_FCS_STRIP_EN
  localparam int FCS = 4;
`else
  localparam int FCS = 0;
`endif
  localparam int D = FCS + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rxd = 8'h00;
  logic        dv = 1'b0;
  logic        er = 1'b0;
  logic        cs = 1'b0;
  logic [18:0] rel_time;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;

  int errors = 0;
  int checks = 0;
  int idle_nonzero = 0;
  logic [8:0] got [$];

  gmii_rx_framer_if stream_if ();

  gmii_rx_framer #(.MAX_LEN(100)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .iv_gmii_rxd      (rxd),
    .i_gmii_rx_dv     (dv),
    .i_gmii_rx_er     (er),
    .i_cycle_start    (cs),
    .stream           (stream_if),
    .ov_relative_time (rel_time),
    .ov_frame_cnt     (frame_cnt),
    .ov_err_cnt       (err_cnt)
  );

  // 125 MHz receive clock.
  always #4 clk = ~clk;

  // Collect emitted bytes on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && stream_if.o_data_wr) got.push_back(stream_if.ov_data);
    if (!stream_if.o_data_wr && stream_if.ov_data != 9'd0) idle_nonzero++;
  end

  task automatic applyStimulus(input logic [7:0] b, input logic v, input logic e, input logic c);
    @(negedge clk);
    rxd = b;
    dv  = v;
    er  = e;
    cs  = c;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // Preamble of npre 0x55 bytes, SFD, nbytes counting bytes, then one dv-low cycle.
  task automatic sendFrame(input int npre, input int nbytes, input int er_at, input int cs_at,
                           input logic end_er);
    for (int i = 0; i < npre; i++) applyStimulus(8'h55, 1'b1, 1'b0, (i == cs_at));
    applyStimulus(8'hD5, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < nbytes; k++) applyStimulus(8'(k), 1'b1, (k == er_at), 1'b0);
    applyStimulus(8'h00, 1'b0, end_er, 1'b0);
  endtask

  function automatic logic [8:0] peek(input int idx);
    if (idx >= 0 && idx < got.size()) return got[idx];
    return 9'bx;
  endfunction

  function automatic int markCount();
    int n = 0;
    foreach (got[i]) if (got[i][8]) n++;
    return n;
  endfunction

  function automatic int seqErrors();
    int n = 0;
    foreach (got[i]) if (got[i][7:0] != 8'(i)) n++;
    return n;
  endfunction

  initial begin
    $display("[TB] gmii_rx_framer bench, FCS held back = %0d", FCS);

    // Reset state.
    idleCycles(3);
    checkOutput("reset_data", 32'(stream_if.ov_data), 32'd0);
    checkOutput("reset_wr", 32'(stream_if.o_data_wr), 32'd0);
    checkOutput("reset_rel_time", 32'(rel_time), 32'd0);
    checkOutput("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("reset_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(2);

    // Normal 64-byte frame, ending with dv low and er high together.
    got.delete();
    sendFrame(7, 64, -1, -1, 1'b1);
    idleCycles(D + 2);
    checkOutput("f64_len", 32'(got.size()), 32'(64 - FCS));
    checkOutput("f64_first", 32'(peek(0)), 32'h100);
    checkOutput("f64_second", 32'(peek(1)), 32'h001);
    checkOutput("f64_last", 32'(peek(63 - FCS)), 32'h100 + 32'(63 - FCS));
    checkOutput("f64_marks", 32'(markCount()), 32'd2);
    checkOutput("f64_sequence", 32'(seqErrors()), 32'd0);
    checkOutput("f64_frame_cnt", 32'(frame_cnt), 32'd1);
    checkOutput("f64_err_cnt", 32'(err_cnt), 32'd0);

    // Runt: SFD, one byte, dv low.
    got.delete();
    sendFrame(7, 1, -1, -1, 1'b0);
    idleCycles(D + 2);
    checkOutput("runt_len", 32'(got.size()), 32'd0);
    checkOutput("runt_err_cnt", 32'(err_cnt), 32'd1);
    checkOutput("runt_frame_cnt", 32'(frame_cnt), 32'd1);

    // Receive error on byte 20 of a 64-byte frame closes the frame early.
    got.delete();
    sendFrame(7, 64, 20, -1, 1'b0);
    idleCycles(D + 2);
    checkOutput("rxer_len", 32'(got.size()), 32'(21 - D));
    checkOutput("rxer_first", 32'(peek(0)), 32'h100);
    checkOutput("rxer_last", 32'(peek(20 - D)), 32'h100 + 32'(20 - D));
    checkOutput("rxer_marks", 32'(markCount()), 32'd2);
    checkOutput("rxer_err_cnt", 32'(err_cnt), 32'd2);
    checkOutput("rxer_frame_cnt", 32'(frame_cnt), 32'd1);

    // Oversize 200-byte frame truncated at 100, then a back-to-back 10-byte frame.
    got.delete();
    sendFrame(7, 200, -1, -1, 1'b0);
    sendFrame(7, 10, -1, -1, 1'b0);
    idleCycles(D + 2);
    checkOutput("over_len", 32'(got.size()), 32'(100 + 10 - FCS));
    checkOutput("over_first", 32'(peek(0)), 32'h100);
    checkOutput("over_idx98", 32'(peek(98)), 32'h062);
    checkOutput("over_idx99", 32'(peek(99)), 32'h163);
    checkOutput("next_first", 32'(peek(100)), 32'h100);
    checkOutput("next_last", 32'(peek(109 - FCS)), 32'h100 + 32'(9 - FCS));
    checkOutput("over_err_cnt", 32'(err_cnt), 32'd3);
    checkOutput("next_frame_cnt", 32'(frame_cnt), 32'd2);

    // Bad preamble 55 55 AA: whole frame dropped.
    got.delete();
    applyStimulus(8'h55, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h55, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hAA, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hD5, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) applyStimulus(8'(k), 1'b1, 1'b0, 1'b0);
    idleCycles(D + 2);
    checkOutput("badpre_len", 32'(got.size()), 32'd0);
    checkOutput("badpre_err_cnt", 32'(err_cnt), 32'd4);

    // Cycle-start pulse 10 cycles before the SFD.
    got.delete();
    sendFrame(12, 8, -1, 2, 1'b0);
    idleCycles(D + 2);
    checkOutput("reltime_value", 32'(rel_time), 32'd10);
    checkOutput("reltime_len", 32'(got.size()), 32'(8 - FCS));
    checkOutput("reltime_frame_cnt", 32'(frame_cnt), 32'd3);

    // Asynchronous reset at byte 30 of a frame, then a clean frame.
    for (int i = 0; i < 7; i++) applyStimulus(8'h55, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'hD5, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 30; k++) applyStimulus(8'(k), 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rxd   = 8'd30;
    dv    = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_wr", 32'(stream_if.o_data_wr), 32'd0);
    checkOutput("arst_data", 32'(stream_if.ov_data), 32'd0);
    checkOutput("arst_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("arst_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("arst_rel_time", 32'(rel_time), 32'd0);
    idleCycles(2);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(2);
    got.delete();
    sendFrame(7, 16, -1, -1, 1'b0);
    idleCycles(D + 2);
    checkOutput("post_len", 32'(got.size()), 32'(16 - FCS));
    checkOutput("post_first", 32'(peek(0)), 32'h100);
    checkOutput("post_last", 32'(peek(15 - FCS)), 32'h100 + 32'(15 - FCS));
    checkOutput("post_sequence", 32'(seqErrors()), 32'd0);
    checkOutput("post_frame_cnt", 32'(frame_cnt), 32'd1);
    checkOutput("post_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("idle_data_zero", 32'(idle_nonzero), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
